// File: rtl/jtag_dmi_master.sv
// jtag_dmi_master: sequences a JTAG TAP to perform 40-bit DMI DR scans.
// Each TAP step is one TCK period of 2*TCK_DIV clk cycles; TMS/TDI change when
// TCK falls, TDO is sampled on the last clk of the low phase.
// The DMI instruction is loaded once after reset, then reused for every scan.
// Optional feature macro: JTAG_DMI_AUTO_FETCH_EN -- a read is followed by an
// automatic nop scan so that the reported response carries the read data.
module jtag_dmi_master #(
  parameter int                TCK_DIV    = 4,
  parameter int                IR_LEN     = 5,
  parameter logic [IR_LEN-1:0] DMI_IR     = 5'b10001,
  parameter int                DMI_ABITS  = 6,
  parameter int                IDLE_STEPS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_op_i,
  input  logic [DMI_ABITS-1:0] req_addr_i,
  input  logic [31:0]          req_data_i,
  output logic                 rsp_valid_o,
  output logic [31:0]          rsp_data_o,
  output logic [1:0]           rsp_status_o,
  output logic                 busy_o,
  output logic                 jtag_TCK_o,
  output logic                 jtag_TMS_o,
  output logic                 jtag_TDI_o,
  input  logic                 jtag_TDO_i
);

  localparam int DR_LEN  = DMI_ABITS + 34;
  localparam int CNT_MAX = (DR_LEN > 2 * TCK_DIV) ? DR_LEN : 2 * TCK_DIV;
  localparam int CW      = $clog2(CNT_MAX);

  // State names describe the TAP state reached by the step taken in that state.
  typedef enum logic [4:0] {
    S_RESET, S_RST_RTI, S_IDLE,
    S_IR_SELDR, S_IR_SELIR, S_IR_CAP, S_IR_ENT, S_IR_SHIFT, S_IR_UPD, S_IR_RTI,
    S_DR_SEL, S_DR_CAP, S_DR_ENT, S_DR_SHIFT, S_DR_UPD, S_DR_IDLE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       step_q, step_d;
  logic [CW-1:0]       div_q;
  logic [DR_LEN-1:0]   sr_q, sr_d;
  logic [IR_LEN-1:0]   ir_sr_q, ir_sr_d;
  logic                tdo_q;
  logic                tck_q, tms_q, tdi_q;
  logic                tms_d, tdi_d;
  logic                ready_q, rsp_valid_q, busy_q, ir_loaded_q;
  logic [31:0]         rsp_data_q;
  logic [1:0]          rsp_status_q;
`ifdef JTAG_DMI_AUTO_FETCH_EN
  logic [DMI_ABITS-1:0] addr_q;
  logic                 fetch_pend_q;
`endif

  // Step-boundary decode: where the sequence goes after the current TAP step,
  // plus the TMS/TDI levels to present for the following step.
  always_comb begin
    state_d = state_q;
    step_d  = '0;
    sr_d    = sr_q;
    ir_sr_d = ir_sr_q;
    case (state_q)
      S_RESET:    if (step_q == CW'(4)) state_d = S_RST_RTI;
                  else step_d = step_q + 1'b1;
      S_RST_RTI:  state_d = S_IDLE;
      S_IR_SELDR: state_d = S_IR_SELIR;
      S_IR_SELIR: state_d = S_IR_CAP;
      S_IR_CAP:   state_d = S_IR_ENT;
      S_IR_ENT:   state_d = S_IR_SHIFT;
      S_IR_SHIFT: begin
        ir_sr_d = ir_sr_q >> 1;
        if (step_q == CW'(IR_LEN - 1)) state_d = S_IR_UPD;
        else step_d = step_q + 1'b1;
      end
      S_IR_UPD:   state_d = S_IR_RTI;
      S_IR_RTI:   state_d = S_DR_SEL;
      S_DR_SEL:   state_d = S_DR_CAP;
      S_DR_CAP:   state_d = S_DR_ENT;
      S_DR_ENT:   state_d = S_DR_SHIFT;
      S_DR_SHIFT: begin
        sr_d = {tdo_q, sr_q[DR_LEN-1:1]};
        if (step_q == CW'(DR_LEN - 1)) state_d = S_DR_UPD;
        else step_d = step_q + 1'b1;
      end
      S_DR_UPD:   state_d = S_DR_IDLE;
      S_DR_IDLE: begin
        if (step_q == CW'(IDLE_STEPS - 1)) begin
`ifdef JTAG_DMI_AUTO_FETCH_EN
          if (fetch_pend_q) begin
            state_d = S_DR_SEL;
            sr_d    = {addr_q, 32'h0, 2'b00};
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: ;
    endcase

    tms_d = 1'b0;
    case (state_d)
      S_RESET, S_IR_SELDR, S_IR_SELIR, S_IR_UPD, S_DR_SEL, S_DR_UPD: tms_d = 1'b1;
      S_IR_SHIFT: tms_d = (step_d == CW'(IR_LEN - 1));
      S_DR_SHIFT: tms_d = (step_d == CW'(DR_LEN - 1));
      default:    tms_d = 1'b0;
    endcase

    tdi_d = 1'b0;
    if (state_d == S_IR_SHIFT)      tdi_d = ir_sr_d[0];
    else if (state_d == S_DR_SHIFT) tdi_d = sr_d[0];
  end

  // Main sequencer: request handshake, TCK phase generation, step advance, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      step_q       <= '0;
      div_q        <= '0;
      sr_q         <= '0;
      ir_sr_q      <= '0;
      tdo_q        <= 1'b0;
      tck_q        <= 1'b0;
      tms_q        <= 1'b1;
      tdi_q        <= 1'b0;
      ready_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      busy_q       <= 1'b1;
      ir_loaded_q  <= 1'b0;
`ifdef JTAG_DMI_AUTO_FETCH_EN
      addr_q       <= '0;
      fetch_pend_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tck_q  <= 1'b0;
          tms_q  <= 1'b0;
          tdi_q  <= 1'b0;
          div_q  <= '0;
          step_q <= '0;
          if (req_valid_i && ready_q) begin
            // op 11 is reserved and scanned as a nop
            sr_q    <= {req_addr_i, req_data_i, (req_op_i == 2'b11) ? 2'b00 : req_op_i};
            ir_sr_q <= DMI_IR;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            tms_q   <= 1'b1;
            state_q <= ir_loaded_q ? S_DR_SEL : S_IR_SELDR;
`ifdef JTAG_DMI_AUTO_FETCH_EN
            addr_q       <= req_addr_i;
            fetch_pend_q <= (req_op_i == 2'b01);
`endif
          end
        end
        S_DONE: begin
          rsp_valid_q  <= 1'b1;
          rsp_data_q   <= sr_q[33:2];
          rsp_status_q <= sr_q[1:0];
          ready_q      <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          if (div_q == CW'(TCK_DIV - 1)) begin
            // last clk of the low phase: sample TDO, then raise TCK
            tdo_q <= jtag_TDO_i;
            tck_q <= 1'b1;
            div_q <= div_q + 1'b1;
          end else if (div_q == CW'(2 * TCK_DIV - 1)) begin
            // end of the high phase: drop TCK and move to the next step
            div_q   <= '0;
            tck_q   <= 1'b0;
            state_q <= state_d;
            step_q  <= step_d;
            sr_q    <= sr_d;
            ir_sr_q <= ir_sr_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            if (state_q == S_IR_RTI) ir_loaded_q <= 1'b1;
            if (state_d == S_IDLE) begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
`ifdef JTAG_DMI_AUTO_FETCH_EN
            if (state_q == S_DR_IDLE && state_d == S_DR_SEL) fetch_pend_q <= 1'b0;
`endif
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_status_o = rsp_status_q;
  assign busy_o       = busy_q;
  assign jtag_TCK_o   = tck_q;
  assign jtag_TMS_o   = tms_q;
  assign jtag_TDI_o   = tdi_q;

endmodule

// File: tb/tb_jtag_dmi_master.sv
// Bench for jtag_dmi_master: a behavioural IEEE 1149.1 TAP with a DMI data
// register answers the scans; every request is checked for response data,
// TAP traffic and handshake timing.
module tb_jtag_dmi_master;

  localparam int TCK_DIV = 4;
  localparam logic [4:0] DMI_IR_V = 5'b10001;
  localparam logic [4:0] IDCODE_V = 5'b00001;
`ifdef JTAG_DMI_AUTO_FETCH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [5:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;
  logic        tck, tms, tdi;
  logic        tdo = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  jtag_dmi_master #(.TCK_DIV(TCK_DIV)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_status_o(rsp_status),
    .busy_o(busy),
    .jtag_TCK_o(tck), .jtag_TMS_o(tms), .jtag_TDI_o(tdi), .jtag_TDO_i(tdo)
  );

  always #5 clk = ~clk;

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      UPIR:  return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  tap_t        tap_st = TLR;
  logic [39:0] dr_sh = '0;
  logic [4:0]  ir_sh = '0;
  logic [4:0]  ir_reg = IDCODE_V;
  logic [39:0] upd_val = '0;
  logic [39:0] cap_q[$];
  int tck_rises = 0, dr_shift_rises = 0, upd_cnt = 0, ir_upd_cnt = 0, rsp_cnt = 0;

  always @(posedge tck) begin
    tck_rises++;
    case (tap_st)
      CAPDR: if (ir_reg == DMI_IR_V) dr_sh = (cap_q.size() > 0) ? cap_q.pop_front() : 40'h0;
      SHDR: begin
        dr_sh = {tdi, dr_sh[39:1]};
        dr_shift_rises++;
      end
      UPDR: if (ir_reg == DMI_IR_V) begin
        upd_val = dr_sh;
        upd_cnt++;
      end
      CAPIR: ir_sh = 5'b00001;
      SHIR:  ir_sh = {tdi, ir_sh[4:1]};
      UPIR: begin
        ir_reg = ir_sh;
        ir_upd_cnt++;
      end
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms);
    if (tap_st == TLR) ir_reg = IDCODE_V;
  end

  always @(negedge tck) begin
    tdo = (tap_st == SHDR) ? dr_sh[0] : (tap_st == SHIR) ? ir_sh[0] : 1'b0;
  end

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int cyc;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 64'(cyc < 4000), 64'd1);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] data,
                        input logic [39:0] cap, input logic [39:0] cap2, input bit exp_ir);
    int r0, i0, u0, p0, cyc;
    bit fetch;
    logic [39:0] exp_cap, exp_upd;
    fetch   = AUTO && (op == 2'b01);
    exp_cap = fetch ? cap2 : cap;
    exp_upd = fetch ? {addr, 32'h0, 2'b00} : {addr, data, (op == 2'b11) ? 2'b00 : op};
    r0 = tck_rises; i0 = ir_upd_cnt; u0 = upd_cnt; p0 = rsp_cnt;
    cap_q.push_back(cap);
    if (fetch) cap_q.push_back(cap2);
    wait_ready("ready_before_req");
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    @(negedge clk);
    check("ready_drop", 64'(req_ready), 64'd0);
    check("busy_after_accept", 64'(busy), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_timeout", 64'(cyc < 4000), 64'd1);
    check("rsp_data", 64'(rsp_data), 64'(exp_cap[33:2]));
    check("rsp_status", 64'(rsp_status), 64'(exp_cap[1:0]));
    check("ready_with_rsp", 64'(req_ready), 64'd1);
    @(negedge clk);
    check("rsp_pulse_width", 64'(rsp_valid), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("tck_rises", 64'(tck_rises - r0), 64'((exp_ir ? 11 : 0) + (fetch ? 96 : 48)));
    check("ir_updates", 64'(ir_upd_cnt - i0), 64'(exp_ir ? 1 : 0));
    check("dmi_updates", 64'(upd_cnt - u0), 64'(fetch ? 2 : 1));
    check("dmi_update_value", 64'(upd_val), 64'(exp_upd));
    check("tap_in_rti", 64'(tap_st), 64'(RTI));
    check("rsp_count", 64'(rsp_cnt - p0), 64'd1);
    $display("[TB] req op=%0d addr=0x%02h data=0x%08h ir=%0d -> rsp data=0x%08h status=%0d rises=%0d",
             op, addr, data, exp_ir, rsp_data, rsp_status, tck_rises - r0);
  endtask

  initial begin
    int r0, p0, d0, cyc;
    logic [1:0] op;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'({rsp_data, rsp_status}), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);

    // reset sequence: 5 TMS=1 steps plus one TMS=0 step
    r0 = tck_rises;
    rst = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (req_ready !== 1'b1 && cyc < 1000);
    check("reset_seq_clks", 64'(cyc), 64'(6 * 2 * TCK_DIV));
    check("reset_seq_rises", 64'(tck_rises - r0), 64'd6);
    check("reset_tap_rti", 64'(tap_st), 64'(RTI));
    check("reset_ir_idcode", 64'(ir_reg), 64'(IDCODE_V));
    $display("[TB] reset sequence done after %0d clk", cyc);

    // first request loads the IR; later ones go straight to the DR
    do_req(2'b10, 6'h10, 32'h0, {6'h0, 32'h12345678, 2'b00}, 40'h0, 1'b1);
    check("ir_is_dmi", 64'(ir_reg), 64'(DMI_IR_V));
    do_req(2'b00, 6'h11, 32'h0, {6'h0, 32'hCAFEF00D, 2'b10}, 40'h0, 1'b0);
    do_req(2'b01, 6'h11, 32'h0, {6'h0, 32'h0BADC0DE, 2'b11}, {6'h0, 32'hDEADBEEF, 2'b00}, 1'b0);

    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      do_req(op, 6'($urandom), $urandom, {8'($urandom), $urandom}, {8'($urandom), $urandom}, 1'b0);
    end

    // reset in the middle of SHIFT_DR
    d0 = dr_shift_rises; p0 = rsp_cnt;
    cap_q.push_back({8'($urandom), $urandom});
    wait_ready("ready_before_abort");
    req_valid = 1'b1; req_op = 2'b10; req_addr = 6'h05; req_data = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while ((dr_shift_rises - d0) < 20 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reach_bit20", 64'(dr_shift_rises - d0), 64'd20);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tck", 64'(tck), 64'd0);
    check("abort_tms", 64'(tms), 64'd1);
    check("abort_busy", 64'(busy), 64'd1);
    check("abort_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready("ready_after_abort");
    check("abort_no_rsp", 64'(rsp_cnt - p0), 64'd0);
    cap_q.delete();
    $display("[TB] mid-scan reset handled");
    do_req(2'b10, 6'h12, $urandom, {8'($urandom), $urandom}, 40'h0, 1'b1);
    do_req(2'b11, 6'($urandom), $urandom, {8'($urandom), $urandom}, 40'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
